hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Consumer end of the decode→execute control path in the 5-stage RISC-V pipeline.
- Keeps its own shadow pipeline of register addresses and write-enable/result-source control through E, M and W.
- From that state it produces stall, flush and forwarding selects for the pipeline registers and the ALU input muxes.
- Placed beside the datapath; drives StallF/StallD/FlushD/FlushE into the F, D and E pipeline registers.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, performance-counter width (used only with the optional feature).

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- Rs1D  input  REG_AW  source reg 1 of instruction in D.
- Rs2D  input  REG_AW  source reg 2 of instruction in D.
- RdD  input  REG_AW  destination reg of instruction in D.
- RegWriteD  input  1  D instruction writes the register file.
- ResultSrcD  input  2  D result source; 2'b01 = load.
- PCSrcE  input  1  branch taken or jump resolved in E.
- StallF  output  1  hold PC.
- StallD  output  1  hold the F→D register.
- FlushD  output  1  clear the F→D register.
- FlushE  output  1  clear the D→E register (bubble).
- ForwardAE  output  2  ALU operand A select: 00 regfile, 01 W result, 10 M ALU result.
- ForwardBE  output  2  same encoding for operand B.
- StallCount  output  CNT_W  load-use stall cycles.
- FlushCount  output  CNT_W  control-flush events.

Behaviour:
- Shadow registers:
  - E stage: Rs1E, Rs2E, RdE, RegWriteE, ResultSrcE.
  - M stage: RdM, RegWriteM.
  - W stage: RdW, RegWriteW.
  - All are cleared to 0 asynchronously on reset.
- Every posedge clk:
  - If FlushE=1, the E shadow loads all zeros; otherwise it loads the D inputs.
  - M shadow <= E shadow.
  - W shadow <= M shadow.
  - Net effect: one cycle per stage, matching the datapath pipeline registers exactly.
- lwStall = ResultSrcE==2'b01 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
- Combinational outputs from current state and inputs:
  - StallF = StallD = lwStall & ~PCSrcE. Redirect wins; the D instruction is squashed anyway.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- ForwardAE priority:
  - 10 if RegWriteM & RdM!=0 & RdM==Rs1E;
  - else 01 if RegWriteW & RdW!=0 & RdW==Rs1E;
  - else 00.
  - ForwardBE uses the same rule with Rs2E.
  - M beats W when both match.
- x0 is never forwarded and never causes a stall.
- Stall timing:
  - A load-use stall lasts exactly one cycle.
  - In the next cycle the load is in M and the bubble is in E, so lwStall deasserts.
  - The dependent instruction then receives the load data through W forwarding (01) one cycle later.
- Reset values (reset asserted, PCSrcE=0, D inputs zero): every output is 0 and both counters are 0.
- Reset mid-operation: shadow state clears immediately, so pending forwards and stalls vanish asynchronously.
- Simultaneous load-use and PCSrcE: StallF=StallD=0, FlushD=1, FlushE=1.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - StallCount increments by 1 on each clock where StallD=1.
  - FlushCount increments by 1 on each clock where PCSrcE=1.
  - Both wrap modulo 2^CNT_W.
  - Both clear on reset.
- Undefined: no counter flops are built; StallCount and FlushCount are constant 0.

Test Plan:
- Reset held, then released with all inputs 0 → all outputs 0 for 5 cycles.
- EX→EX forwarding:
  - Stimulus: add x5 (RdD=5, RegWriteD=1), next cycle Rs1D=5.
  - Response: two cycles after the add is issued, ForwardAE=10 with no stall.
  - One cycle later, with Rs2 of the following instruction =5, ForwardBE=01.
- Load-use:
  - Stimulus: load x7 (ResultSrcD=01, RdD=7), next cycle Rs2D=7.
  - Response: StallF=StallD=FlushE=1 for exactly one cycle; two cycles later ForwardBE=01.
- Double match:
  - Stimulus: RdM=RdW=3, both RegWrite=1, Rs1E=3.
  - Response: ForwardAE=10.
  - Repeat with RdM=RdW=0: ForwardAE=00, and a load into x0 causes no stall.
- Branch taken:
  - Stimulus: PCSrcE=1 for one cycle.
  - Response: FlushD=FlushE=1; the E shadow is zero next cycle.
  - With a coincident load-use: StallD=0.
- With HAZARD_PERF_EN:
  - Stimulus: 3 load-use stalls and 2 taken branches.
  - Response: StallCount=3, FlushCount=2; both are 0 one cycle after reset is asserted mid-run.

Source files
------------

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: decode/execute control bundle between the datapath (master) and the hazard unit (slave)
interface hazard_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] Rs1D;
   logic [REG_AW-1:0] Rs2D;
   logic [REG_AW-1:0] RdD;
   logic              RegWriteD;
   logic [1:0]        ResultSrcD;
   logic              PCSrcE;
   logic              StallF;
   logic              StallD;
   logic              FlushD;
   logic              FlushE;
   logic [1:0]        ForwardAE;
   logic [1:0]        ForwardBE;
   logic [CNT_W-1:0]  StallCount;
   logic [CNT_W-1:0]  FlushCount;
   modport master (
      output Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
   );
   modport slave (
      input  Rs1D, Rs2D, RdD, RegWriteD, ResultSrcD, PCSrcE,
      output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, StallCount, FlushCount
   );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the 5-stage pipeline; HAZARD_PERF_EN adds stall/flush counters
module hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic         clk,
   input  logic         reset,
   hazard_unit_if.slave hu
);
   logic [REG_AW-1:0] rs1_e_q, rs1_e_d, rs2_e_q, rs2_e_d, rd_e_q, rd_e_d;
   logic              reg_write_e_q, reg_write_e_d;
   logic [1:0]        result_src_e_q, result_src_e_d;
   logic [REG_AW-1:0] rd_m_q, rd_m_d, rd_w_q, rd_w_d;
   logic              reg_write_m_q, reg_write_m_d, reg_write_w_q, reg_write_w_d;
   logic              lw_stall, stall, flush_e;
   logic [1:0]        fwd_a, fwd_b;

   // hazard detection and forwarding selects from the shadow pipeline and the D inputs
   always_comb begin
      lw_stall = result_src_e_q == 2'b01 && rd_e_q != '0 && (rd_e_q == hu.Rs1D || rd_e_q == hu.Rs2D);
      stall    = lw_stall && !hu.PCSrcE;
      flush_e  = lw_stall || hu.PCSrcE;
      fwd_a    = (reg_write_m_q && rd_m_q != '0 && rd_m_q == rs1_e_q) ? 2'b10 :
                 (reg_write_w_q && rd_w_q != '0 && rd_w_q == rs1_e_q) ? 2'b01 : 2'b00;
      fwd_b    = (reg_write_m_q && rd_m_q != '0 && rd_m_q == rs2_e_q) ? 2'b10 :
                 (reg_write_w_q && rd_w_q != '0 && rd_w_q == rs2_e_q) ? 2'b01 : 2'b00;
   end

   assign hu.StallF    = stall;
   assign hu.StallD    = stall;
   assign hu.FlushD    = hu.PCSrcE;
   assign hu.FlushE    = flush_e;
   assign hu.ForwardAE = fwd_a;
   assign hu.ForwardBE = fwd_b;

   // next shadow state: E takes D (or a bubble when flushed), M and W follow one stage behind
   always_comb begin
      rs1_e_d        = flush_e ? '0 : hu.Rs1D;
      rs2_e_d        = flush_e ? '0 : hu.Rs2D;
      rd_e_d         = flush_e ? '0 : hu.RdD;
      reg_write_e_d  = flush_e ? 1'b0 : hu.RegWriteD;
      result_src_e_d = flush_e ? 2'b00 : hu.ResultSrcD;
      rd_m_d         = rd_e_q;
      reg_write_m_d  = reg_write_e_q;
      rd_w_d         = rd_m_q;
      reg_write_w_d  = reg_write_m_q;
   end

   // shadow pipeline registers, cleared asynchronously so pending hazards vanish on reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rs1_e_q        <= '0;
         rs2_e_q        <= '0;
         rd_e_q         <= '0;
         reg_write_e_q  <= 1'b0;
         result_src_e_q <= 2'b00;
         rd_m_q         <= '0;
         reg_write_m_q  <= 1'b0;
         rd_w_q         <= '0;
         reg_write_w_q  <= 1'b0;
      end else begin
         rs1_e_q        <= rs1_e_d;
         rs2_e_q        <= rs2_e_d;
         rd_e_q         <= rd_e_d;
         reg_write_e_q  <= reg_write_e_d;
         result_src_e_q <= result_src_e_d;
         rd_m_q         <= rd_m_d;
         reg_write_m_q  <= reg_write_m_d;
         rd_w_q         <= rd_w_d;
         reg_write_w_q  <= reg_write_w_d;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

   // count load-use stall cycles and taken redirects, wrapping naturally
   always_comb begin
      stall_count_d = stall_count_q + CNT_W'(stall);
      flush_count_d = flush_count_q + CNT_W'(hu.PCSrcE);
   end

   // performance counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   assign hu.StallCount = stall_count_q;
   assign hu.FlushCount = flush_count_q;
`else
   assign hu.StallCount = {CNT_W{1'b0}};
   assign hu.FlushCount = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: random and directed stimulus against an instruction-level pipeline model
module tb_hazard_unit;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] src;
   } ins_t;

   ins_t        st [3];
   int unsigned m_stall = 0;
   int unsigned m_flush = 0;

   hazard_unit_if hu ();
   hazard_unit dut (.clk(clk), .reset(reset), .hu(hu));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic m_lw();
      return st[0].src == 2'b01 && st[0].rd != 0 && (st[0].rd == hu.Rs1D || st[0].rd == hu.Rs2D);
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      for (int s = 1; s <= 2; s++)
         if (st[s].rw && st[s].rd != 0 && st[s].rd == rs) return s == 1 ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   // instruction-level model: an instruction advances one stage per clock; flushed slots become empty
   always @(posedge clk) begin
      if (!reset) begin
         if (m_lw() && !hu.PCSrcE) m_stall++;
         if (hu.PCSrcE) m_flush++;
         st[2] = st[1];
         st[1] = st[0];
         st[0] = (m_lw() || hu.PCSrcE) ? ins_t'(0) : ins_t'{hu.Rs1D, hu.Rs2D, hu.RdD, hu.RegWriteD, hu.ResultSrcD};
      end
   end

   always @(posedge reset) begin
      for (int s = 0; s < 3; s++) st[s] = ins_t'(0);
      m_stall = 0;
      m_flush = 0;
   end

   task automatic cmp_all();
      logic lw;
      lw = m_lw();
      chk("StallF", 32'(hu.StallF), 32'(lw && !hu.PCSrcE));
      chk("StallD", 32'(hu.StallD), 32'(lw && !hu.PCSrcE));
      chk("FlushD", 32'(hu.FlushD), 32'(hu.PCSrcE));
      chk("FlushE", 32'(hu.FlushE), 32'(lw || hu.PCSrcE));
      chk("ForwardAE", 32'(hu.ForwardAE), 32'(m_fwd(st[0].rs1)));
      chk("ForwardBE", 32'(hu.ForwardBE), 32'(m_fwd(st[0].rs2)));
`ifdef HAZARD_PERF_EN
      chk("StallCount", hu.StallCount, m_stall);
      chk("FlushCount", hu.FlushCount, m_flush);
`else
      chk("StallCount", hu.StallCount, 32'd0);
      chk("FlushCount", hu.FlushCount, 32'd0);
`endif
   endtask

   task automatic step(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                       input logic w, input logic [1:0] s, input logic p);
      @(negedge clk);
      hu.Rs1D = a;
      hu.Rs2D = b;
      hu.RdD = d;
      hu.RegWriteD = w;
      hu.ResultSrcD = s;
      hu.PCSrcE = p;
      #1;
      cmp_all();
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      #3 reset = 1'b1;
      #1 cmp_all();
      chk("rst_fwd_a", 32'(hu.ForwardAE), 32'd0);
      chk("rst_stall", 32'(hu.StallD), 32'd0);
      @(negedge clk);
      #1 cmp_all();
      chk("rst_cnt_s", hu.StallCount, 32'd0);
      chk("rst_cnt_f", hu.FlushCount, 32'd0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      hu.Rs1D = '0;
      hu.Rs2D = '0;
      hu.RdD = '0;
      hu.RegWriteD = 1'b0;
      hu.ResultSrcD = 2'b00;
      hu.PCSrcE = 1'b0;
      repeat (3) step(0, 0, 0, 0, 0, 0);
      chk("reset_outs", {hu.StallF, hu.StallD, hu.FlushD, hu.FlushE, hu.ForwardAE, hu.ForwardBE}, 32'd0);
      chk("reset_cnt", hu.StallCount | hu.FlushCount, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (5) step(0, 0, 0, 0, 0, 0);
      chk("idle_outs", {hu.StallF, hu.StallD, hu.FlushD, hu.FlushE, hu.ForwardAE, hu.ForwardBE}, 32'd0);
      // three load-use stalls and two taken branches
      repeat (3) begin
         step(0, 0, 7, 1, 2'b01, 0);
         step(0, 7, 0, 0, 0, 0);
         chk("lu_stall", 32'(hu.StallD), 32'd1);
         chk("lu_flushe", 32'(hu.FlushE), 32'd1);
         step(0, 7, 0, 0, 0, 0);
         chk("lu_one_cyc", 32'(hu.StallD), 32'd0);
         step(0, 0, 0, 0, 0, 0);
         chk("lu_fwd_b", 32'(hu.ForwardBE), 32'd1);
      end
      step(0, 0, 0, 0, 0, 1);
      chk("br_flushd", 32'(hu.FlushD), 32'd1);
      chk("br_flushe", 32'(hu.FlushE), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);
`ifdef HAZARD_PERF_EN
      chk("perf_stall", hu.StallCount, 32'd3);
      chk("perf_flush", hu.FlushCount, 32'd2);
`endif
      rst_pulse();
      // EX->EX then W forwarding
      step(0, 0, 5, 1, 0, 0);
      step(5, 0, 0, 0, 0, 0);
      step(0, 5, 0, 0, 0, 0);
      chk("ex_fwd_a", 32'(hu.ForwardAE), 32'd2);
      chk("ex_nostall", 32'(hu.StallD), 32'd0);
      step(0, 0, 0, 0, 0, 0);
      chk("w_fwd_b", 32'(hu.ForwardBE), 32'd1);
      // double match: M wins over W
      step(0, 0, 3, 1, 0, 0);
      step(0, 0, 3, 1, 0, 0);
      step(3, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("dbl_fwd_a", 32'(hu.ForwardAE), 32'd2);
      // x0 never forwards or stalls
      step(0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 2'b01, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("x0_nostall", 32'(hu.StallD), 32'd0);
      chk("x0_fwd_a", 32'(hu.ForwardAE), 32'd0);
      // branch coincident with load-use
      step(0, 0, 9, 1, 2'b01, 0);
      step(9, 0, 0, 0, 0, 1);
      chk("co_stalld", 32'(hu.StallD), 32'd0);
      chk("co_flushd", 32'(hu.FlushD), 32'd1);
      chk("co_flushe", 32'(hu.FlushE), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("co_bubble", 32'(hu.ForwardAE), 32'd0);
      // random traffic over a small register set to provoke frequent matches
      for (int i = 0; i < 600; i++) begin
         if (i == 300) rst_pulse();
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 5) == 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end
endmodule
